// File: rtl/run_ctrl_pkg.sv
// Shared types for the yChip run sequencer: FSM states, stop-cause codes
// and a width-generic saturating increment.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_LIMIT = 3'd1,
    CAUSE_BREAK = 3'd2,
    CAUSE_HALT  = 3'd3,
    CAUSE_ABORT = 3'd4
  } cause_t;

  localparam int unsigned MAX_CNT_W = 64;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                   input int unsigned w);
    logic [MAX_CNT_W-1:0] top;
    top = (w >= MAX_CNT_W) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= top) ? top : v + 64'd1;
  endfunction

endpackage

// File: rtl/run_controller_if.sv
// Host/core-facing signal bundle of the run sequencer; slave is the controller side.
interface run_controller_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NUM_BP = 2
);
  logic                     start;
  logic                     abort;
  logic                     step_mode;
  logic                     step_req;
  logic [ADDR_W-1:0]        entry_point;
  logic [CNT_W-1:0]         step_limit;
  logic [NUM_BP*ADDR_W-1:0] bp_addr;
  logic [NUM_BP-1:0]        bp_en;
  logic [ADDR_W-1:0]        pc;
  logic [31:0]              ins;
  logic [ADDR_W-1:0]        entry_out;
  logic                     chip_int;
  logic                     chip_en;
  logic                     busy;
  logic                     done;
  logic [2:0]               done_cause;
  logic [CNT_W-1:0]         steps_done;

  modport master (
    output start, abort, step_mode, step_req, entry_point, step_limit,
           bp_addr, bp_en, pc, ins,
    input  entry_out, chip_int, chip_en, busy, done, done_cause, steps_done
  );

  modport slave (
    input  start, abort, step_mode, step_req, entry_point, step_limit,
           bp_addr, bp_en, pc, ins,
    output entry_out, chip_int, chip_en, busy, done, done_cause, steps_done
  );
endinterface

// File: rtl/run_bp_match.sv
// Parallel address comparators for the breakpoint slots, OR-reduced to one hit.
module run_bp_match #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned NUM_BP = 2
) (
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     hit
);

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W])) hit = 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Program-run sequencer for the yChip core: one-cycle INT load, then gated
// execution via chip_en until limit, breakpoint, halt or abort.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 32,
  parameter int unsigned       CNT_W         = 16,
  parameter int unsigned       NUM_BP        = 2,
  parameter logic [ADDR_W-1:0] DEFAULT_ENTRY = ADDR_W'('h28),
  parameter logic [31:0]       HALT_INS      = 32'h0
) (
  input logic             clk,
  input logic             rst,
  run_controller_if.slave bus
);

  state_t            state, nxt;
  cause_t            cause_q, stop_cause;
  logic              mode_q;
  logic [CNT_W-1:0]  limit_q;
  logic [CNT_W-1:0]  steps_q;
  logic [ADDR_W-1:0] entry_q;
  logic              bp_hit, halt_hit, limit_hit;
  logic              active, stop_now, can_start;

  run_bp_match #(
    .ADDR_W(ADDR_W),
    .NUM_BP(NUM_BP)
  ) u_bp (
    .pc     (bus.pc),
    .bp_addr(bus.bp_addr),
    .bp_en  (bus.bp_en),
    .hit    (bp_hit)
  );

  assign active    = (state == S_RUN) || (state == S_PAUSE);
  assign can_start = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign halt_hit  = (bus.ins == HALT_INS);
  assign limit_hit = (limit_q != '0) && (steps_q == limit_q);
  assign stop_now  = active && (bus.abort || halt_hit || bp_hit || limit_hit);

  always_comb begin
    stop_cause = CAUSE_LIMIT;
    if (bus.abort)     stop_cause = CAUSE_ABORT;
    else if (halt_hit) stop_cause = CAUSE_HALT;
    else if (bp_hit)   stop_cause = CAUSE_BREAK;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (can_start) nxt = S_LOAD;
      S_LOAD:         nxt = mode_q ? S_PAUSE : S_RUN;
      S_RUN, S_PAUSE: if (stop_now) nxt = S_DONE;
      default:        nxt = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops them without a clock.
  assign bus.chip_int   = (state == S_LOAD);
  assign bus.chip_en    = (state == S_LOAD) ||
                          ((state == S_RUN) && !stop_now) ||
                          ((state == S_PAUSE) && bus.step_req && !stop_now);
  assign bus.busy       = (state == S_LOAD) || active;
  assign bus.done       = (state == S_DONE);
  assign bus.done_cause = cause_q;
  assign bus.steps_done = steps_q;
  assign bus.entry_out  = entry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cause_q <= CAUSE_NONE;
      mode_q  <= 1'b0;
      limit_q <= '0;
      steps_q <= '0;
      entry_q <= DEFAULT_ENTRY;
    end else begin
      state <= nxt;
      if (can_start) begin
        entry_q <= bus.entry_point;
        mode_q  <= bus.step_mode;
        limit_q <= bus.step_limit;
        steps_q <= '0;
        cause_q <= CAUSE_NONE;
      end else begin
        if (active && bus.chip_en)
          steps_q <= CNT_W'(sat_inc(MAX_CNT_W'(steps_q), CNT_W));
        if (stop_now) cause_q <= stop_cause;
      end
    end
  end

endmodule
